time_scheduler: RTL and testbench
=================================

TIME_SCHEDULER -- requirements
Module: time_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per 1 Hz tick; legal range 4 to 2^PRESC_WIDTH.
REQ-002 SHALL have parameter PRESC_WIDTH, default 26, prescaler counter width.
REQ-003 SHALL have parameter SEC_MAX, default 59, last seconds value before minute carry.
REQ-004 SHALL have parameter MIN_MAX, default 59, last minutes value before hour carry.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port btn_mode  in  1  mode button level, already synchronized and debounced.
REQ-008 SHALL have port btn_inc  in  1  increment button level, already synchronized and debounced.
REQ-009 SHALL have port sec_val  in  6  current seconds count from the seconds counter.
REQ-010 SHALL have port min_val  in  6  current minutes count from the minutes counter.
REQ-011 SHALL have port add_sec  out  1  registered one-cycle increment request to the seconds counter.
REQ-012 SHALL have port add_min  out  1  registered one-cycle increment request to the minutes counter.
REQ-013 SHALL have port add_hour  out  1  registered one-cycle increment request to the hours counter.
REQ-014 SHALL have port mode  out  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
REQ-015 SHALL have port tick  out  1  registered one-cycle prescaler tick pulse.
REQ-016 SHALL have port blink  out  1  field-blink enable; 0 in RUN.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be 1 in the cycle after the count equals TICK_DIV-1, else 0.
REQ-018 Button press SHALL be a rising edge: current level 1 and previous registered level 0; one press per edge, no auto-repeat.
REQ-019 FSM transitions on mode press SHALL be: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; all other states hold.
REQ-020 On leaving SET_SEC for RUN, prescaler SHALL load 0 and blink SHALL clear, so the first RUN tick comes TICK_DIV cycles later.
REQ-021 In RUN, on a prescaler wrap cycle N, add_sec SHALL be 1 in cycle N+1.
REQ-022 In RUN, on the same wrap, add_min SHALL also be 1 in N+1 if sec_val==SEC_MAX sampled in cycle N.
REQ-023 In RUN, on the same wrap, add_hour SHALL also be 1 in N+1 if sec_val==SEC_MAX and min_val==MIN_MAX sampled in cycle N (no ripple delay).
REQ-024 Hour wrap SHALL be left to the hours counter; no hour-value input exists.
REQ-025 In RUN, inc presses SHALL be ignored.
REQ-026 In SET_x, an inc press in cycle N SHALL give a one-cycle pulse in N+1 on the selected field's add line only; no carry into other fields.
REQ-027 In SET_x, prescaler SHALL keep running but SHALL NOT generate add_sec; each wrap SHALL toggle blink.
REQ-028 Simultaneous mode and inc press SHALL act on mode only; the inc press is dropped.
REQ-029 A tick and an inc press coinciding in a SET state SHALL give exactly one add pulse on the selected field.
REQ-030 add_sec, add_min and add_hour SHALL each be at most one cycle wide; no two-cycle pulses in any state.

Reset
REQ-031 Reset low at a clock edge SHALL set: state RUN, prescaler 0, tick/add_sec/add_min/add_hour/blink 0, mode 0.
REQ-032 Reset SHALL set the button previous-level registers to 1, so a button held through reset release is not a press.
REQ-033 Reset asserted mid-operation, including during a pending add pulse, SHALL cancel that pulse in the same edge.

Verification (TICK_DIV=4)
REQ-034 Release reset, buttons low, sec_val=5 -> add_sec pulses every 4 cycles, add_min/add_hour stay 0, mode=0.
REQ-035 sec_val=59, min_val=10 at wrap -> add_sec and add_min high in the same single cycle, add_hour 0.
REQ-036 sec_val=59, min_val=59 at wrap -> add_sec, add_min, add_hour all high in one cycle.
REQ-037 Four mode presses -> mode 1,2,3,0; in mode 2, three inc presses -> exactly three add_min pulses, no add_sec; blink toggles every 4 cycles, is 0 after return to RUN.
REQ-038 btn_mode and btn_inc rise in the same cycle in RUN -> mode=1, no add pulse.
REQ-039 btn_inc high through reset release in SET-capable run -> no press; reset pulled mid-add -> all outputs 0 next cycle.

Source files
------------

// File: rtl/time_scheduler.sv
// Clock-setting scheduler: 1 Hz prescaler, RUN/SET mode FSM and registered
// increment requests to the external seconds/minutes/hours counters.
module time_scheduler #(
  parameter int TICK_DIV    = 50000000,
  parameter int PRESC_WIDTH = 26,
  parameter int SEC_MAX     = 59,
  parameter int MIN_MAX     = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] sec_val,
  input  logic [5:0] min_val,
  output logic       add_sec,
  output logic       add_min,
  output logic       add_hour,
  output logic [1:0] mode,
  output logic       tick,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(TICK_DIV - 1);

  state_t                 state_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] presc_d;
  logic                   mode_prev_q;
  logic                   inc_prev_q;
  logic                   tick_q;
  logic                   blink_q;
  logic                   add_sec_q;
  logic                   add_min_q;
  logic                   add_hour_q;

  logic wrap;
  logic mode_press;
  logic inc_act;
  logic sec_at_max;
  logic min_at_max;

  assign wrap       = (presc_q == PRESC_LAST);
  assign presc_d    = wrap ? '0 : presc_q + PRESC_WIDTH'(1);
  assign mode_press = btn_mode & ~mode_prev_q;
  // A mode press in the same cycle swallows any inc press.
  assign inc_act    = btn_inc & ~inc_prev_q & ~mode_press;
  assign sec_at_max = (sec_val == 6'(SEC_MAX));
  assign min_at_max = (min_val == 6'(MIN_MAX));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      presc_q     <= '0;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
      add_sec_q   <= 1'b0;
      add_min_q   <= 1'b0;
      add_hour_q  <= 1'b0;
    end else begin
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      tick_q      <= wrap;
      presc_q     <= presc_d;
      add_sec_q   <= 1'b0;
      add_min_q   <= 1'b0;
      add_hour_q  <= 1'b0;

      // Carries are decoded from the sampled counter values, not rippled.
      case (state_q)
        RUN: begin
          add_sec_q  <= wrap;
          add_min_q  <= wrap & sec_at_max;
          add_hour_q <= wrap & sec_at_max & min_at_max;
        end
        SET_HOUR: add_hour_q <= inc_act;
        SET_MIN:  add_min_q  <= inc_act;
        SET_SEC:  add_sec_q  <= inc_act;
        default:  ;
      endcase

      if (state_q != RUN && wrap) begin
        blink_q <= ~blink_q;
      end

      if (mode_press) begin
        case (state_q)
          RUN:      state_q <= SET_HOUR;
          SET_HOUR: state_q <= SET_MIN;
          SET_MIN:  state_q <= SET_SEC;
          default: begin
            // Restart the second so the first RUN tick is a full period away.
            state_q <= RUN;
            presc_q <= '0;
            blink_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign add_sec  = add_sec_q;
  assign add_min  = add_min_q;
  assign add_hour = add_hour_q;
  assign mode     = state_q;
  assign tick     = tick_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_time_scheduler.sv
// Bench for time_scheduler: behavioural model checked every cycle, plus
// directed literal checks and a randomized button/counter phase.
module tb_time_scheduler;
  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec_val = 6'd5;
  logic [5:0] min_val = 6'd0;
  logic       add_sec, add_min, add_hour, tick, blink;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  time_scheduler #(.TICK_DIV(TD), .PRESC_WIDTH(4), .SEC_MAX(59), .MIN_MAX(59)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_val(sec_val), .min_val(min_val), .add_sec(add_sec), .add_min(add_min),
    .add_hour(add_hour), .mode(mode), .tick(tick), .blink(blink)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state number, cycle-within-second, expected outputs.
  int m_state = 0;
  int m_cnt = 0;
  bit m_tick = 0, m_as = 0, m_am = 0, m_ah = 0, m_blink = 0;
  bit m_pm = 1, m_pi = 1;
  bit mp, ip, w, sel;

  always @(posedge clock) begin
    if (!reset) begin
      m_state = 0; m_cnt = 0; m_tick = 0; m_as = 0; m_am = 0; m_ah = 0;
      m_blink = 0; m_pm = 1; m_pi = 1;
    end else begin
      mp  = btn_mode && !m_pm;
      ip  = btn_inc && !m_pi;
      sel = ip && !mp;
      w   = (m_cnt == TD - 1);
      m_tick = w;
      m_as = (m_state == 0 && w) || (m_state == 3 && sel);
      m_am = (m_state == 0 && w && sec_val == 59) || (m_state == 2 && sel);
      m_ah = (m_state == 0 && w && sec_val == 59 && min_val == 59) || (m_state == 1 && sel);
      if (m_state != 0 && w) m_blink = !m_blink;
      m_cnt = (m_cnt + 1) % TD;
      if (mp) begin
        if (m_state == 3) begin
          m_cnt = 0;
          m_blink = 0;
        end
        m_state = (m_state + 1) % 4;
      end
      m_pm = btn_mode;
      m_pi = btn_inc;
    end
  end

  bit p_as = 0, p_am = 0, p_ah = 0;
  always @(negedge clock) begin
    check("mode", int'(mode), m_state);
    check("tick", int'(tick), int'(m_tick));
    check("add_sec", int'(add_sec), int'(m_as));
    check("add_min", int'(add_min), int'(m_am));
    check("add_hour", int'(add_hour), int'(m_ah));
    check("blink", int'(blink), int'(m_blink));
    check("pulse_width", int'((p_as && add_sec) || (p_am && add_min) || (p_ah && add_hour)), 0);
    p_as = add_sec; p_am = add_min; p_ah = add_hour;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_add_sec(input string name);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!add_sec && n < 12);
    check({name, "_timeout"}, int'(add_sec), 1);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(1);
    btn_mode = 1'b0; step(1);
  endtask

  initial begin
    int cnt_min, cnt_sec, cnt_hour, tg;
    bit pb;

    // Release with buttons low: add_sec every TD cycles from release.
    reset = 1'b0; step(2);
    reset = 1'b1;
    check("rst_mode", int'(mode), 0);
    check("rst_add_sec", int'(add_sec), 0);
    step(3); check("first_tick_early", int'(add_sec), 0);
    step(1); check("first_tick", int'(add_sec), 1);
    check("first_tick_min", int'(add_min), 0);
    step(3); check("second_tick_early", int'(add_sec), 0);
    step(1); check("second_tick", int'(add_sec), 1);
    $display("scenario run_ticks done");

    // Minute carry, then hour carry, in the same cycle as add_sec.
    sec_val = 6'd59; min_val = 6'd10;
    wait_add_sec("min_carry");
    check("min_carry_min", int'(add_min), 1);
    check("min_carry_hour", int'(add_hour), 0);
    step(1); check("min_carry_width", int'(add_min), 0);
    min_val = 6'd59;
    wait_add_sec("hour_carry");
    check("hour_carry_min", int'(add_min), 1);
    check("hour_carry_hour", int'(add_hour), 1);
    sec_val = 6'd5; min_val = 6'd0;
    $display("scenario carries done");

    // Mode walk; three inc presses in SET_MIN; blink behaviour.
    press_mode(); check("mode1", int'(mode), 1);
    press_mode(); check("mode2", int'(mode), 2);
    cnt_min = 0; cnt_sec = 0;
    repeat (3) begin
      btn_inc = 1'b1; step(1); cnt_min += int'(add_min); cnt_sec += int'(add_sec);
      btn_inc = 1'b0; step(1); cnt_min += int'(add_min); cnt_sec += int'(add_sec);
    end
    step(1); cnt_min += int'(add_min); cnt_sec += int'(add_sec);
    check("set_min_pulses", cnt_min, 3);
    check("set_min_no_sec", cnt_sec, 0);
    tg = 0; pb = blink;
    repeat (16) begin
      step(1);
      if (blink != pb) tg++;
      pb = blink;
    end
    check("blink_toggles", tg, 4);
    press_mode(); check("mode3", int'(mode), 3);
    btn_mode = 1'b1; step(1);
    check("mode0", int'(mode), 0);
    check("blink_run", int'(blink), 0);
    btn_mode = 1'b0;
    step(3); check("resume_tick_early", int'(add_sec), 0);
    step(1); check("resume_tick", int'(add_sec), 1);
    $display("scenario set_mode done");

    // Simultaneous mode and inc rise: mode wins, inc dropped.
    btn_mode = 1'b1; btn_inc = 1'b1; step(1);
    check("simul_mode", int'(mode), 1);
    check("simul_hour", int'(add_hour), 0);
    step(1); check("simul_hour_later", int'(add_hour), 0);
    btn_mode = 1'b0; btn_inc = 1'b0; step(1);
    press_mode(); press_mode(); press_mode();
    check("simul_back_run", int'(mode), 0);
    $display("scenario simultaneous done");

    // Inc held through reset release is not a press.
    btn_inc = 1'b1; reset = 1'b0; step(2);
    reset = 1'b1; step(1);
    press_mode();
    cnt_hour = 0;
    repeat (6) begin step(1); cnt_hour += int'(add_hour); end
    check("held_inc_mode", int'(mode), 1);
    check("held_inc_no_hour", cnt_hour, 0);
    // Reset coinciding with a pending inc pulse cancels it.
    btn_inc = 1'b0; step(1);
    btn_inc = 1'b1; reset = 1'b0; step(1);
    check("rst_cancel_hour", int'(add_hour), 0);
    check("rst_cancel_mode", int'(mode), 0);
    reset = 1'b1; btn_inc = 1'b0; step(1);
    wait_add_sec("pre_cancel");
    reset = 1'b0; step(1);
    check("rst_cancel_sec", int'(add_sec), 0);
    check("rst_cancel_tick", int'(tick), 0);
    reset = 1'b1;
    $display("scenario reset done");

    // Randomized buttons, counter values and occasional resets.
    repeat (3000) begin
      step(1);
      if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 2) == 0) btn_inc = ~btn_inc;
      sec_val = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 58));
      min_val = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 58));
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    step(2);
    $display("scenario random done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
